matrix_frame_scheduler: RTL and testbench

//  Sequencer for the 4-frame 7x5 LED pattern mux. Drives SEL0/SEL1 to cycle frames with programmable

---
 rtl/matrix_frame_scheduler.sv | 84 ++++++++
 tb/tb_matrix_frame_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler: cycles 4 LED frames with programmable dwell and row-scans the selected frame
module matrix_frame_scheduler #(
  parameter int SCAN_DIV = 500,
  parameter int DWELL_W  = 8
) (
  input  logic               CLK,
  input  logic               NRST,
  input  logic               EN,
  input  logic               STEP,
  input  logic               DIR,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic [34:0]        FRAME_IN,
  output logic               SEL0,
  output logic               SEL1,
  output logic [6:0]         ROW,
  output logic [4:0]         COL,
  output logic               FRAME_TICK
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [DWELL_W-1:0] scan_q, scan_d;
  logic               pend_q, pend_d;
  logic [1:0]         frame_q, frame_d;
  logic               tick_q, tick_d;
  logic [4:0]         col_q, col_d;
  logic               row_end, boundary, dwell_hit, adv;
  logic [DWELL_W:0]   scan_inc, dwell_eff;

  // Next-state logic: row scan sequencing plus frame advance decision at the scan boundary
  always_comb begin
    row_end   = state_q == SHOW && pre_q == '0;
    boundary  = row_end && row_q == 3'd6;
    scan_inc  = {1'b0, scan_q} + {{DWELL_W{1'b0}}, 1'b1};
    dwell_eff = DWELL == '0 ? {{DWELL_W{1'b0}}, 1'b1} : {1'b0, DWELL};
    dwell_hit = scan_inc >= dwell_eff;
    adv       = boundary && (EN ? dwell_hit : (pend_q || STEP));
    scan_d    = !boundary ? scan_q : (EN && !dwell_hit) ? scan_inc[DWELL_W-1:0] : '0;
    pend_d    = !EN && !boundary && (pend_q || STEP);
    frame_d   = !adv ? frame_q : DIR ? frame_q - 2'd1 : frame_q + 2'd1;
    tick_d    = adv;
    state_d   = state_q == BLANK ? SHOW : row_end ? BLANK : SHOW;
    pre_d     = state_q == BLANK ? PRE_MAX : row_end ? pre_q : pre_q - PW'(1);
    row_d     = !row_end ? row_q : row_q == 3'd6 ? 3'd0 : row_q + 3'd1;
    col_d     = state_q == BLANK ? FRAME_IN[{3'b0, row_q} * 6'd5 +: 5] : col_q;
  end

  // State registers with asynchronous reset so outputs clear without a clock
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= BLANK;
      row_q   <= '0;
      pre_q   <= '0;
      scan_q  <= '0;
      pend_q  <= 1'b0;
      frame_q <= '0;
      tick_q  <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      col_q   <= col_d;
    end
  end

  // Output decode: row drive is blanked outside SHOW so at most one row is ever lit
  always_comb begin
    ROW        = state_q == SHOW ? 7'd1 << row_q : 7'd0;
    COL        = col_q;
    SEL0       = frame_q[1];
    SEL1       = frame_q[0];
    FRAME_TICK = tick_q;
  end
endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb_matrix_frame_scheduler: directed and random stimulus checked against a cycle-count reference model
module tb_matrix_frame_scheduler;
  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        EN = 1'b0;
  logic        STEP = 1'b0;
  logic        DIR = 1'b0;
  logic [7:0]  DWELL = 8'd0;
  logic [34:0] FRAME_IN;
  logic        SEL0, SEL1, FRAME_TICK;
  logic [6:0]  ROW;
  logic [4:0]  COL;
  logic [34:0] fmem [4];

  int t, m_frame, m_cnt, passes, fails, total, ticks;
  logic m_pend, m_tick;
  logic [4:0] m_col;

  assign FRAME_IN = fmem[{SEL0, SEL1}];

  matrix_frame_scheduler #(.SCAN_DIV(4), .DWELL_W(8)) dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .STEP(STEP), .DIR(DIR), .DWELL(DWELL),
    .FRAME_IN(FRAME_IN), .SEL0(SEL0), .SEL1(SEL1), .ROW(ROW), .COL(COL),
    .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_frame = 0; m_cnt = 0; m_pend = 1'b0; m_tick = 1'b0; m_col = 5'd0;
  endtask

  // One clock edge of the reference: t counts cycles since reset release, SCAN_DIV=4 -> 5-cycle rows, 35-cycle scans
  task automatic model_edge();
    int d;
    logic bnd, adv;
    logic [34:0] w;
    bnd = (t % 35) == 34;
    adv = 1'b0;
    if (t % 5 == 0) begin
      w = fmem[m_frame] >> (((t % 35) / 5) * 5);
      m_col = w[4:0];
    end
    d = (DWELL == 0) ? 1 : int'(DWELL);
    if (EN) begin
      m_pend = 1'b0;
      if (bnd) begin
        if (m_cnt + 1 >= d) begin adv = 1'b1; m_cnt = 0; end
        else m_cnt++;
      end
    end else if (bnd) begin
      adv = m_pend || STEP;
      m_pend = 1'b0;
      m_cnt = 0;
    end else if (STEP) m_pend = 1'b1;
    m_tick = adv;
    if (adv) m_frame = (m_frame + (DIR ? 3 : 1)) % 4;
    t++;
  endtask

  task automatic check_all();
    int er;
    er = (!NRST || t % 5 == 0) ? 0 : (1 << ((t % 35) / 5));
    chk("row", 32'(ROW), er);
    chk("col", 32'(COL), 32'(m_col));
    chk("sel", 32'({SEL0, SEL1}), m_frame);
    chk("tick", 32'(FRAME_TICK), 32'(m_tick));
  endtask

  task automatic cyc();
    @(posedge CLK);
    if (NRST) model_edge();
    #1;
    check_all();
    if (FRAME_TICK) ticks++;
  endtask

  task automatic pulse_step();
    STEP = 1'b1;
    cyc();
    STEP = 1'b0;
  endtask

  initial begin
    int guard;
    passes = 0; fails = 0; total = 0; ticks = 0;
    for (int k = 0; k < 4; k++) fmem[k] = {$urandom, $urandom};
    model_reset();
    #1;
    check_all();
    cyc();
    cyc();
    // Scenario: forward auto-run, dwell 2
    EN = 1'b1; DIR = 1'b0; DWELL = 8'd2; NRST = 1'b1; ticks = 0;
    repeat (285) cyc();
    chk("fwd_ticks", ticks, 4);
    chk("fwd_frame", 32'({SEL0, SEL1}), 0);
    // Row r of every frame carries r+1
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 7; r++) fmem[k][r*5 +: 5] = 5'(r + 1);
    repeat (70) cyc();
    // Reverse with dwell 1 and dwell 0
    DIR = 1'b1; DWELL = 8'd1; ticks = 0;
    repeat (140) cyc();
    chk("rev_d1_ticks", ticks, 4);
    DWELL = 8'd0; ticks = 0;
    repeat (140) cyc();
    chk("rev_d0_ticks", ticks, 4);
    // Paused: no advance without STEP
    EN = 1'b0; ticks = 0;
    repeat (200) cyc();
    chk("pause_ticks", ticks, 0);
    repeat (5) cyc();
    ticks = 0;
    pulse_step();
    repeat (10) cyc();
    pulse_step();
    repeat (40) cyc();
    chk("two_steps_one_adv", ticks, 1);
    // STEP ignored while running, and pending must not survive into a pause
    EN = 1'b1; DWELL = 8'd5; ticks = 0;
    repeat (3) begin
      pulse_step();
      repeat (9) cyc();
    end
    EN = 1'b0;
    repeat (30) cyc();
    chk("step_while_en", ticks, 0);
    // Dwell lowered below the running count; FRAME_IN changes mid-row
    EN = 1'b1; DWELL = 8'd3; ticks = 0;
    for (int i = 0; i < 70; i++) begin
      if (i % 13 == 7) fmem[$urandom_range(0, 3)] = {$urandom, $urandom};
      cyc();
    end
    chk("dwell3_no_adv", ticks, 0);
    DWELL = 8'd1;
    repeat (30) cyc();
    chk("dwell_lowered_adv", ticks, 1);
    // Random mix of all controls
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) EN = ~EN;
      STEP = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) DIR = ~DIR;
      DWELL = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) fmem[$urandom_range(0, 3)] = {$urandom, $urandom};
      cyc();
    end
    STEP = 1'b0;
    // Asynchronous reset during row 3 while frame 2 is shown
    EN = 1'b1; DIR = 1'b0; DWELL = 8'd1;
    guard = 0;
    while (!(m_frame == 2 && t % 35 == 17) && guard < 400) begin
      cyc();
      guard++;
    end
    chk("reach_row3_frame2", guard < 400, 1);
    chk("pre_reset_row", 32'(ROW), 32'h08);
    @(negedge CLK);
    NRST = 1'b0;
    model_reset();
    #1;
    chk("rst_row", 32'(ROW), 0);
    chk("rst_col", 32'(COL), 0);
    chk("rst_sel", 32'({SEL0, SEL1}), 0);
    chk("rst_tick", 32'(FRAME_TICK), 0);
    cyc();
    cyc();
    DWELL = 8'd2; ticks = 0; NRST = 1'b1;
    repeat (69) cyc();
    chk("post_rst_no_adv", ticks, 0);
    repeat (6) cyc();
    chk("post_rst_adv", ticks, 1);
    chk("post_rst_frame", 32'({SEL0, SEL1}), 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
